// File: rtl/systolic_drain_if.sv
// Row output channel of systolic_drain: one full result row per valid/ready beat.
// The master drives the row fields and the slave answers with row_ready.
interface systolic_drain_if #(
    parameter int COLUMN_NUMBER = 4
);
    logic [COLUMN_NUMBER*8-1:0] row_data;
    logic [7:0]                 row_idx;
    logic                       row_valid;
    logic                       row_ready;

    modport master (output row_data, output row_idx, output row_valid, input row_ready);
    modport slave  (input row_data, input row_idx, input row_valid, output row_ready);
endinterface

// File: rtl/systolic_drain.sv
// Captures the systolic array's bottom-edge results (bottom row first) into a row buffer,
// then streams the rows top-first over a valid/ready channel. Optional: DRAIN_CHECKSUM_EN.
module systolic_drain #(
    parameter int ROW_NUMBER    = 4,
    parameter int COLUMN_NUMBER = 4,
    parameter int DRAIN_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       drain_start,
    input  logic [COLUMN_NUMBER*8-1:0] col_in,
    systolic_drain_if.master           rows,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    output logic [15:0]                checksum
);

    localparam int         IDX_W     = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1;
    localparam logic [7:0] LAST_BEAT = 8'(ROW_NUMBER - 1);
    localparam logic [3:0] LAT_LOAD  = 4'((DRAIN_LATENCY > 0) ? (DRAIN_LATENCY - 1) : 0);
    localparam bit         ZERO_LAT  = (DRAIN_LATENCY == 0);

    if (ROW_NUMBER < 1 || ROW_NUMBER > 256) begin : g_bad_rows
        $error("systolic_drain: ROW_NUMBER must be in 1..256");
    end
    if (DRAIN_LATENCY < 0 || DRAIN_LATENCY > 15) begin : g_bad_latency
        $error("systolic_drain: DRAIN_LATENCY must be in 0..15");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        CAPTURE = 3'd2,
        EMIT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                     state_r, state_nxt;
    logic [3:0]                 lat_r, lat_nxt;
    logic [7:0]                 beat_r, beat_nxt;
    logic [7:0]                 row_idx_r;
    logic [COLUMN_NUMBER*8-1:0] row_data_r;
    logic                       row_valid_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       overrun_r;
    logic                       capture_s;
    logic                       handshake_s;
    logic                       last_beat_s;
    logic                       last_row_s;
    logic [IDX_W-1:0]           wr_row_s;
    logic [IDX_W-1:0]           rd_row_s;
    logic [COLUMN_NUMBER*8-1:0] buf_r [ROW_NUMBER];

    // Beats arrive bottom row first, so beat k lands in row ROW_NUMBER-1-k.
    assign last_beat_s = (beat_r == LAST_BEAT);
    assign last_row_s  = (row_idx_r == LAST_BEAT);
    assign wr_row_s    = IDX_W'(LAST_BEAT - beat_r);
    assign rd_row_s    = IDX_W'(row_idx_r + 8'd1);

    // Next-state and capture/handshake strobes.
    always_comb begin
        state_nxt   = state_r;
        lat_nxt     = lat_r;
        beat_nxt    = beat_r;
        capture_s   = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (drain_start) begin
                    if (ZERO_LAT) begin
                        capture_s = 1'b1;
                        state_nxt = last_beat_s ? EMIT : CAPTURE;
                    end else begin
                        state_nxt = WAIT;
                        lat_nxt   = LAT_LOAD;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (lat_r == 4'd0) begin
                    state_nxt = CAPTURE;
                end else begin
                    lat_nxt = lat_r - 4'd1;
                end
            end
            CAPTURE: begin
                capture_s = 1'b1;
                state_nxt = last_beat_s ? EMIT : CAPTURE;
            end
            EMIT: begin
                handshake_s = row_valid_r && rows.row_ready;
                if (handshake_s && last_row_s) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = EMIT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (capture_s) begin
            beat_nxt = last_beat_s ? 8'd0 : (beat_r + 8'd1);
        end else begin
            beat_nxt = beat_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            lat_r       <= 4'd0;
            beat_r      <= 8'd0;
            row_idx_r   <= 8'd0;
            row_data_r  <= {(COLUMN_NUMBER*8){1'b0}};
            row_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            lat_r       <= lat_nxt;
            beat_r      <= beat_nxt;
            row_valid_r <= (state_nxt == EMIT);
            busy_r      <= (state_nxt != IDLE);
            done_r      <= (state_nxt == DONE);
            if (drain_start && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            // The final beat is row 0, so it goes straight to the output register.
            if (capture_s && last_beat_s) begin
                row_idx_r  <= 8'd0;
                row_data_r <= col_in;
            end else if (handshake_s && !last_row_s) begin
                row_idx_r  <= row_idx_r + 8'd1;
                row_data_r <= buf_r[rd_row_s];
            end
        end
    end

    // Result buffer; contents are meaningless until captured, so no reset.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            buf_r[wr_row_s] <= col_in;
        end
    end

`ifdef DRAIN_CHECKSUM_EN
    function automatic logic [15:0] byte_sum(input logic [COLUMN_NUMBER*8-1:0] v);
        logic [15:0] s;
        s = 16'd0;
        for (int j = 0; j < COLUMN_NUMBER; j++) begin
            s = s + {8'd0, v[8*j +: 8]};
        end
        return s;
    endfunction

    logic        accept_s;
    logic [15:0] checksum_r;

    assign accept_s = (state_r == IDLE) && drain_start;

    // Running byte sum of captured beats; a zero-latency start captures beat 0 at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_r <= 16'd0;
        end else if (accept_s) begin
            checksum_r <= capture_s ? byte_sum(col_in) : 16'd0;
        end else if (capture_s) begin
            checksum_r <= checksum_r + byte_sum(col_in);
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = 16'd0;
`endif

    assign rows.row_data  = row_data_r;
    assign rows.row_idx   = row_idx_r;
    assign rows.row_valid = row_valid_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign overrun        = overrun_r;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: latency-1 instance for the main cases,
// a zero-latency instance for the same-cycle capture path.
module tb_systolic_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds, ds0;
    logic [31:0] col, col0;
    logic        busy, done, overrun;
    logic        busy0, done0, overrun0;
    logic [15:0] csum, csum0;
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] B0 = 32'h04030201, B1 = 32'h08070605;
    localparam logic [31:0] B2 = 32'h0C0B0A09, B3 = 32'h100F0E0D;
    localparam logic [31:0] C0 = 32'h11223344, C1 = 32'h55667788;
    localparam logic [31:0] C2 = 32'h99AABBCC, C3 = 32'hDDEEFF00;
`ifdef DRAIN_CHECKSUM_EN
    localparam logic [15:0] CSUM_B  = 16'h0088;
    localparam logic [15:0] CSUM_Z0 = 16'h0314;
`else
    localparam logic [15:0] CSUM_B  = 16'h0000;
    localparam logic [15:0] CSUM_Z0 = 16'h0000;
`endif

    always #5 clk = ~clk;

    systolic_drain_if #(.COLUMN_NUMBER(4)) bif ();
    systolic_drain_if #(.COLUMN_NUMBER(4)) bif0 ();

    systolic_drain #(.ROW_NUMBER(4), .COLUMN_NUMBER(4), .DRAIN_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .drain_start(ds), .col_in(col), .rows(bif.master),
        .busy(busy), .done(done), .overrun(overrun), .checksum(csum)
    );

    systolic_drain #(.ROW_NUMBER(4), .COLUMN_NUMBER(4), .DRAIN_LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .drain_start(ds0), .col_in(col0), .rows(bif0.master),
        .busy(busy0), .done(done0), .overrun(overrun0), .checksum(csum0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [31:0] idx, input logic [31:0] data);
        chk({tag, "_valid"}, 32'(bif.row_valid), 32'd1);
        chk({tag, "_idx"}, 32'(bif.row_idx), idx);
        chk({tag, "_data"}, bif.row_data, data);
    endtask

    // Called one step after edge P0; returns one step after P6 (first row_valid).
    task automatic feed(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                        input logic [31:0] b3, input bit pulse2);
        ds = 1'b1;
        tick();
        ds = 1'b0;
        tick();
        col = b0;
        ds  = pulse2;
        tick();
        col = b1;
        ds  = 1'b0;
        tick();
        col = b2;
        tick();
        col = b3;
        chk("valid_early", 32'(bif.row_valid), 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b0; ds = 1'b0; ds0 = 1'b0; col = 32'd0; col0 = 32'd0;
        bif.row_ready = 1'b1; bif0.row_ready = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_valid", 32'(bif.row_valid), 32'd0);
        chk("rst_idx", 32'(bif.row_idx), 32'd0);
        chk("rst_data", bif.row_data, 32'd0);
        chk("rst_csum", 32'(csum), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic drain with row_ready held high
        feed(B0, B1, B2, B3, 1'b0);
        chk_row("basic_r0", 32'd0, B3);
        chk("basic_busy", 32'(busy), 32'd1);
        tick(); chk_row("basic_r1", 32'd1, B2);
        tick(); chk_row("basic_r2", 32'd2, B1);
        tick(); chk_row("basic_r3", 32'd3, B0);
        chk("basic_done_early", 32'(done), 32'd0);
        tick();
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_valid_drop", 32'(bif.row_valid), 32'd0);
        chk("basic_csum", 32'(csum), 32'(CSUM_B));
        tick();
        chk("basic_done_clear", 32'(done), 32'd0);
        chk("basic_idle", 32'(busy), 32'd0);
        chk("basic_overrun", 32'(overrun), 32'd0);

        // Backpressure: row 1 stalled three cycles, then ready toggles
        feed(B0, B1, B2, B3, 1'b0);
        chk_row("bp_r0", 32'd0, B3);
        tick(); chk_row("bp_r1", 32'd1, B2);
        bif.row_ready = 1'b0;
        tick(); chk_row("bp_stall1", 32'd1, B2);
        tick(); chk_row("bp_stall2", 32'd1, B2);
        tick(); chk_row("bp_stall3", 32'd1, B2);
        bif.row_ready = 1'b1;
        tick(); chk_row("bp_r2", 32'd2, B1);
        bif.row_ready = 1'b0;
        tick(); chk_row("bp_r2_hold", 32'd2, B1);
        bif.row_ready = 1'b1;
        tick(); chk_row("bp_r3", 32'd3, B0);
        bif.row_ready = 1'b0;
        tick(); chk_row("bp_r3_hold", 32'd3, B0);
        chk("bp_done_early", 32'(done), 32'd0);
        bif.row_ready = 1'b1;
        tick();
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_valid_drop", 32'(bif.row_valid), 32'd0);
        tick();

        // Overrun: second drain_start two cycles after the first
        feed(B0, B1, B2, B3, 1'b1);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk_row("ovr_r0", 32'd0, B3);
        tick(); chk_row("ovr_r1", 32'd1, B2);
        tick(); chk_row("ovr_r2", 32'd2, B1);
        tick(); chk_row("ovr_r3", 32'd3, B0);
        chk("ovr_done_early", 32'(done), 32'd0);
        tick();
        chk("ovr_done", 32'(done), 32'd1);
        chk("ovr_csum", 32'(csum), 32'(CSUM_B));
        tick();
        chk("ovr_done_once", 32'(done), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        tick();
        chk("ovr_no_restart", 32'(busy), 32'd0);

        // Async reset during capture beat 2, then a fresh drain
        ds = 1'b1;
        tick(); ds = 1'b0;
        tick(); col = B0;
        tick(); col = B1;
        tick(); col = B2;
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(bif.row_valid), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("arst_no_done", 32'(done), 32'd0);
        feed(C0, C1, C2, C3, 1'b0);
        chk_row("arst_r0", 32'd0, C3);
        tick(); chk_row("arst_r1", 32'd1, C2);
        tick(); chk_row("arst_r2", 32'd2, C1);
        tick(); chk_row("arst_r3", 32'd3, C0);
        tick();
        chk("arst_done", 32'(done), 32'd1);
        tick();

        // Zero-latency instance: beat 0 sampled in the drain_start cycle
        ds0 = 1'b1; col0 = 32'hAABBCCDD;
        tick(); ds0 = 1'b0; col0 = 32'h00000001;
        tick(); col0 = 32'h00000002;
        tick(); col0 = 32'h00000003;
        tick();
        chk("z0_r0_valid", 32'(bif0.row_valid), 32'd1);
        chk("z0_r0_data", bif0.row_data, 32'h00000003);
        tick(); tick(); tick();
        chk("z0_r3_idx", 32'(bif0.row_idx), 32'd3);
        chk("z0_r3_data", bif0.row_data, 32'hAABBCCDD);
        tick();
        chk("z0_done", 32'(done0), 32'd1);
        chk("z0_csum", 32'(csum0), 32'(CSUM_Z0));
        tick();
        chk("z0_idle", 32'(busy0), 32'd0);
        chk("z0_overrun", 32'(overrun0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
